// File: rtl/dpram_t_row_loader.sv
// dpram_t_row_loader
//   Collects a stream of DATA_WIDTH-bit words into NUM_WORDS-word packed rows and
//   writes each completed row to port A of a dual-port RAM, for num_rows rows.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   start     : one-cycle pulse, begins a load (honoured only while idle)
//   num_rows  : rows to load, sampled with start; 0 or >2^ROW_AWIDTH loads 2^ROW_AWIDTH
//   in_valid  : upstream word valid
//   in_data   : upstream word
//   in_ready  : loader accepts a word this cycle
//   wren_a    : RAM port A write strobe (one cycle per row)
//   address_a : RAM row address (holds its last value between writes)
//   data_a    : packed row, word 0 in the LSBs
//   busy      : high whenever a load is in progress
//   done      : one-cycle pulse after the final row write
module dpram_t_row_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned ROW_AWIDTH = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ROW_AWIDTH:0]             num_rows,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic                            wren_a,
  output logic [ROW_AWIDTH-1:0]           address_a,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] data_a,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned RowWidth = NUM_WORDS * DATA_WIDTH;
  localparam int unsigned WcWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WcWidth-1:0] LastWord = WcWidth'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ROW_AWIDTH-1:0]   row_cnt_q, row_cnt_d;
  logic [WcWidth-1:0]      word_cnt_q, word_cnt_d;
  logic [ROW_AWIDTH-1:0]   last_row_q, last_row_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wren_q, wren_d;
  logic [ROW_AWIDTH-1:0]   addr_q, addr_d;
  logic [RowWidth-1:0]     data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    word_cnt_d = word_cnt_q;
    last_row_d = last_row_q;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFill;
          row_cnt_d  = '0;
          word_cnt_d = '0;
          // Store effective count minus one. The MSB set means >= 2^ROW_AWIDTH,
          // which saturates; zero in the low bits wraps to all-ones, giving the full RAM.
          last_row_d = num_rows[ROW_AWIDTH] ? '1 : num_rows[ROW_AWIDTH-1:0] - 1'b1;
        end
      end
      StFill: begin
        if (in_valid && in_ready_q) begin
          data_d[word_cnt_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
          if (word_cnt_q == LastWord) begin
            word_cnt_d = '0;
            state_d    = StWrite;
            addr_d     = row_cnt_q;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        if (row_cnt_q == last_row_q) begin
          state_d = StDone;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = StFill;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the decoded next state.
    in_ready_d = (state_d == StFill);
    wren_d     = (state_d == StWrite);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
      last_row_q <= '0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      word_cnt_q <= word_cnt_d;
      last_row_q <= last_row_d;
      in_ready_q <= in_ready_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wren_a    = wren_q;
  assign address_a = addr_q;
  assign data_a    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dpram_t_row_loader.sv
// Randomized bench for dpram_t_row_loader. A beat-count reference model predicts,
// cycle by cycle, in_ready/wren_a/done/busy and the address/packed data of each row write.
module tb_dpram_t_row_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned RW = DW * NW;
  localparam int unsigned MaxRows = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_rows;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wren_a;
  logic [AW-1:0] address_a;
  logic [RW-1:0] data_a;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [DW-1:0] words [MaxRows*NW];
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpram_t_row_loader #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW),
    .ROW_AWIDTH(AW)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_rows (num_rows),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wren_a   (wren_a),
    .address_a(address_a),
    .data_a   (data_a),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] row_image(input int r);
    logic [RW-1:0] img;
    img = '0;
    for (int k = 0; k < NW; k++) img[k*DW +: DW] = words[r*NW + k];
    return img;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".in_ready"}, RW'(in_ready), '0);
    check_eq({tag, ".wren_a"}, RW'(wren_a), '0);
    check_eq({tag, ".address_a"}, RW'(address_a), '0);
    check_eq({tag, ".data_a"}, data_a, '0);
    check_eq({tag, ".busy"}, RW'(busy), '0);
    check_eq({tag, ".done"}, RW'(done), '0);
  endtask

  // mode: 0 = in_valid always high, 1 = toggling, 2 = random.
  // abort_at >= 0: assert reset once that many beats have been accepted.
  task automatic run_load(input int nr, input int mode, input int abort_at, input bit poke_start);
    int   eff, sent, phase, rows_written, dut_writes, last_wcyc, budget;
    bit   v, aborted;
    eff = (nr == 0 || nr > int'(MaxRows)) ? int'(MaxRows) : nr;
    for (int i = 0; i < eff * int'(NW); i++) words[i] = DW'($urandom);
    sent = 0; rows_written = 0; dut_writes = 0; last_wcyc = 0; budget = 0; aborted = 0;

    @(negedge clk);
    start    = 1'b1;
    num_rows = (AW+1)'(nr);
    in_valid = 1'b0;
    phase    = 1;  // 0 idle, 1 collecting words, 2 row write, 3 done pulse

    while (phase != 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
      start = 1'b0;
      check_eq("in_ready", RW'(in_ready), RW'(phase == 1));
      check_eq("wren_a", RW'(wren_a), RW'(phase == 2));
      check_eq("done", RW'(done), RW'(phase == 3));
      check_eq("busy", RW'(busy), RW'(1'b1));
      if (wren_a) dut_writes++;
      if (phase == 2) begin
        exp_addr = AW'(rows_written);
        check_eq("address_a.write", RW'(address_a), RW'(exp_addr));
        check_eq("data_a.row", data_a, row_image(rows_written));
        if (mode == 0 && rows_written > 0) check_eq("row_spacing", RW'(cyc - last_wcyc), RW'(NW + 1));
        last_wcyc = cyc;
        rows_written++;
      end else begin
        check_eq("address_a.hold", RW'(address_a), RW'(exp_addr));
      end

      if (abort_at >= 0 && sent == abort_at) begin
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        exp_addr = '0;
        @(negedge clk);
        check_eq("abort.idle_busy", RW'(busy), '0);
        check_eq("abort.idle_wren", RW'(wren_a), '0);
        aborted = 1;
        phase   = 0;
      end else begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (budget % 2) == 1;
          default: v = $urandom_range(0, 1) == 1;
        endcase
        in_valid = v;
        in_data  = (v && phase == 1) ? words[sent] : DW'($urandom);
        if (poke_start && (phase == 3 || (phase == 1 && $urandom_range(0, 7) == 0))) start = 1'b1;
        case (phase)
          1: if (v) begin
            sent++;
            if (sent % int'(NW) == 0) phase = 2;
          end
          2: phase = (rows_written == eff) ? 3 : 1;
          3: phase = 0;
          default: phase = 0;
        endcase
      end
    end

    if (budget >= 20000) check_eq("timeout", RW'(1'b1), '0);
    if (!aborted) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      check_eq("end.busy", RW'(busy), '0);
      check_eq("end.done", RW'(done), '0);
      check_eq("end.in_ready", RW'(in_ready), '0);
      check_eq("end.write_count", RW'(dut_writes), RW'(eff));
      repeat (3) begin
        @(negedge clk);
        check_eq("idle.wren_a", RW'(wren_a), '0);
        check_eq("idle.busy", RW'(busy), '0);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    num_rows = '0;
    exp_addr = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    start    = 1'b1;  // reset outranks start
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("reset.start_ignored", RW'(busy), '0);
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;

    run_load(1, 0, -1, 1'b0);              // single row, gap-free
    run_load(0, 0, -1, 1'b0);              // 0 means full RAM
    run_load(2, 1, -1, 1'b0);              // toggling valid
    run_load(3, 2, -1, 1'b1);              // random valid, stray starts
    run_load(5, 2, 3 * NW + 17, 1'b0);     // reset mid row 3
    run_load(1, 0, -1, 1'b0);              // reload from address 0
    run_load(100, 0, -1, 1'b1);            // saturates to full RAM

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dpram_t_row_loader.md
DPRAM_T_ROW_LOADER -- requirements
Module: dpram_t_row_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one word.
REQ-002 SHALL have parameter NUM_WORDS, default 32, words packed per RAM row.
REQ-003 SHALL have parameter ROW_AWIDTH, default 6, RAM row address width (64 rows).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a load; honoured only in IDLE.
REQ-007 SHALL have port num_rows, input, ROW_AWIDTH+1, rows to load; sampled on accepted start; 0 means 64.
REQ-008 SHALL have port in_valid, input, 1, upstream word valid.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, upstream word.
REQ-010 SHALL have port in_ready, output, 1, loader accepts a word this cycle.
REQ-011 SHALL have port wren_a, output, 1, write strobe to RAM port A.
REQ-012 SHALL have port address_a, output, ROW_AWIDTH, RAM row address.
REQ-013 SHALL have port data_a, output, NUM_WORDS*DATA_WIDTH, packed row.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse after final row write.

Function
REQ-016 SHALL implement states IDLE, FILL, WRITE, DONE; all outputs registered.
REQ-017 IDLE: in_ready=0; start=1 -> FILL, row_cnt=0, word_cnt=0, num_rows latched.
REQ-018 FILL: in_ready=1; beat accepted when in_valid&&in_ready; no beat -> state and counters hold.
REQ-019 Accepted beat k SHALL be written to data_a[k*DATA_WIDTH +: DATA_WIDTH]; word 0 in LSBs.
REQ-020 Beat with word_cnt=NUM_WORDS-1 -> WRITE next cycle, word_cnt wraps to 0, in_ready drops to 0 same edge.
REQ-021 WRITE: wren_a=1 for exactly one cycle, address_a=row_cnt, data_a=complete packed row; latency one cycle from last beat acceptance to wren_a.
REQ-022 WRITE exit: row_cnt==effective num_rows-1 -> DONE; else row_cnt+1 -> FILL.
REQ-023 DONE: done=1 for one cycle, then IDLE; busy falls with transition to IDLE.
REQ-024 address_a SHALL hold its last value outside WRITE; wren_a=0 outside WRITE.
REQ-025 data_a SHALL change only on accepted beats; not cleared between rows.
REQ-026 start outside IDLE SHALL be ignored, including the DONE cycle.
REQ-027 Row address SHALL never exceed 2^ROW_AWIDTH-1; num_rows>64 SHALL be treated as 64.
REQ-028 Throughput: NUM_WORDS+1 cycles per row with in_valid held high.

Reset
REQ-029 reset=1 SHALL force IDLE, row_cnt=0, word_cnt=0, in_ready=0, wren_a=0, address_a=0, data_a=0, busy=0, done=0.
REQ-030 reset mid-load SHALL abandon the partial row with no RAM write; reset has priority over start and in_valid.

Verification
REQ-031 start, num_rows=1, in_data=0..31 continuous -> in_ready 32 cycles, wren_a once, address_a=0, data_a word k=k, done one cycle after wren_a.
REQ-032 num_rows=0, 2048 continuous beats -> 64 writes at addresses 0..63 in order, spacing 33 cycles, single done.
REQ-033 in_valid toggling 1/0 every cycle, num_rows=2 -> 2 writes, packed data identical to gap-free run, no word loss.
REQ-034 reset asserted after beat 17 of row 3 -> next cycle all outputs at reset values, no wren_a; new start reloads from address 0.
REQ-035 start pulsed during FILL and during DONE -> ignored; row_cnt and write count unchanged, busy stays until DONE->IDLE.
